// File: rtl/avr_cpu_decode_if.sv
// Decode-stage bundle: opcode/LPM inputs from fetch, fetch control back, micro-op to execute.
// master = fetch/execute side (drives opcode), slave = decode stage.
interface avr_cpu_decode_if;
    logic [15:0] opcode;
    logic [15:0] z_ptr;
    logic [7:0]  lpm_data;
    logic [15:0] pc_update;
    logic        hold;
    logic        write_stack;
    logic        read_stack;
    logic        lpm_read;
    logic [15:0] lpm_addr;
    logic        ex_valid;
    logic [3:0]  ex_class;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rr;
    logic [15:0] ex_imm;
    logic        illegal;

    modport master (
        output opcode, z_ptr, lpm_data,
        input  pc_update, hold, write_stack, read_stack, lpm_read, lpm_addr,
        input  ex_valid, ex_class, ex_rd, ex_rr, ex_imm, illegal
    );

    modport slave (
        input  opcode, z_ptr, lpm_data,
        output pc_update, hold, write_stack, read_stack, lpm_read, lpm_addr,
        output ex_valid, ex_class, ex_rd, ex_rr, ex_imm, illegal
    );
endinterface

// File: rtl/avr_cpu_decode.sv
// AVR decode stage: combinational fetch control, registered micro-op one cycle after IDLE decode.
// Multi-cycle LDS/STS/LPM and branch flush sequenced by a 4-state FSM; AVR_DECODE_ILLEGAL_TRAP_EN enables illegal trap.
module avr_cpu_decode #(
    parameter logic [15:0] RST_OPCODE = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    avr_cpu_decode_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SECOND, LPM_WAIT, FLUSH} state_t;

    state_t      r_state;
    logic [4:0]  r_reg;
    logic        r_alt;
    logic        r_ex_valid;
    logic [3:0]  r_ex_class;
    logic [4:0]  r_ex_rd;
    logic [4:0]  r_ex_rr;
    logic [15:0] r_ex_imm;

    logic [4:0]  w_d;
    logic [4:0]  w_r;
    logic [3:0]  w_alu_cls;
    logic        w_is_nop, w_is_ldi, w_is_rjmp, w_is_rcall, w_is_ret;
    logic        w_is_lds, w_is_sts, w_is_lpm_r0, w_is_lpm_z, w_is_lpm_zp;

    assign w_d          = bus.opcode[8:4];
    assign w_r          = {bus.opcode[9], bus.opcode[3:0]};
    assign w_is_nop     = (bus.opcode == 16'h0000) || (bus.opcode == RST_OPCODE);
    assign w_is_ldi     = (bus.opcode[15:12] == 4'hE);
    assign w_is_rjmp    = (bus.opcode[15:12] == 4'hC);
    assign w_is_rcall   = (bus.opcode[15:12] == 4'hD);
    assign w_is_ret     = (bus.opcode == 16'h9508);
    assign w_is_lds     = (bus.opcode[15:9] == 7'b1001000) && (bus.opcode[3:0] == 4'h0);
    assign w_is_sts     = (bus.opcode[15:9] == 7'b1001001) && (bus.opcode[3:0] == 4'h0);
    assign w_is_lpm_r0  = (bus.opcode == 16'h95C8);
    assign w_is_lpm_z   = ((bus.opcode[15:9] == 7'b1001000) && (bus.opcode[3:0] == 4'h4)) || w_is_lpm_r0;
    assign w_is_lpm_zp  = (bus.opcode[15:9] == 7'b1001000) && (bus.opcode[3:0] == 4'h5);

    // Two-register ALU group; 0 means "not an ALU opcode".
    always_comb begin
        w_alu_cls = 4'd0;
        case (bus.opcode[15:10])
            6'b000011: w_alu_cls = 4'd1;
            6'b000111: w_alu_cls = 4'd2;
            6'b000110: w_alu_cls = 4'd3;
            6'b001000: w_alu_cls = 4'd4;
            6'b001001: w_alu_cls = 4'd5;
            6'b001010: w_alu_cls = 4'd6;
            6'b001011: w_alu_cls = 4'd7;
            default:   w_alu_cls = 4'd0;
        endcase
    end

    // Fetch control is combinational so a branch redirects fetch in the same cycle.
    always_comb begin
        bus.pc_update   = 16'h0000;
        bus.hold        = 1'b0;
        bus.write_stack = 1'b0;
        bus.read_stack  = 1'b0;
        bus.lpm_read    = 1'b0;
        bus.lpm_addr    = 16'h0000;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (!w_is_nop && (w_is_rjmp || w_is_rcall)) begin
                        bus.pc_update   = {{4{bus.opcode[11]}}, bus.opcode[11:0]};
                        bus.hold        = 1'b1;
                        bus.write_stack = w_is_rcall;
                    end else if (!w_is_nop && w_is_ret) begin
                        bus.read_stack = 1'b1;
                        bus.hold       = 1'b1;
                    end else if (!w_is_nop && (w_is_lpm_z || w_is_lpm_zp)) begin
                        bus.lpm_read = 1'b1;
                        bus.lpm_addr = bus.z_ptr;
                        bus.hold     = 1'b1;
                    end
                end
                LPM_WAIT: bus.hold = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef AVR_DECODE_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign bus.illegal = r_illegal;
`else
    assign bus.illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_reg      <= 5'd0;
            r_alt      <= 1'b0;
            r_ex_valid <= 1'b0;
            r_ex_class <= 4'd0;
            r_ex_rd    <= 5'd0;
            r_ex_rr    <= 5'd0;
            r_ex_imm   <= 16'h0000;
`ifdef AVR_DECODE_ILLEGAL_TRAP_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            r_ex_valid <= 1'b0;
            r_ex_class <= 4'd0;
            r_ex_rd    <= 5'd0;
            r_ex_rr    <= 5'd0;
            r_ex_imm   <= 16'h0000;
`ifdef AVR_DECODE_ILLEGAL_TRAP_EN
            r_illegal  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_is_nop) begin
                        r_ex_valid <= 1'b1;
                    end else if (w_alu_cls != 4'd0) begin
                        r_ex_valid <= 1'b1;
                        r_ex_class <= w_alu_cls;
                        r_ex_rd    <= w_d;
                        r_ex_rr    <= w_r;
                    end else if (w_is_ldi) begin
                        r_ex_valid <= 1'b1;
                        r_ex_class <= 4'd8;
                        r_ex_rd    <= {1'b1, bus.opcode[7:4]};
                        r_ex_imm   <= {8'h00, bus.opcode[11:8], bus.opcode[3:0]};
                    end else if (w_is_lds || w_is_sts) begin
                        r_reg   <= w_d;
                        r_alt   <= w_is_sts;
                        r_state <= SECOND;
                    end else if (w_is_lpm_z || w_is_lpm_zp) begin
                        r_reg   <= w_is_lpm_r0 ? 5'd0 : w_d;
                        r_alt   <= w_is_lpm_zp;
                        r_state <= LPM_WAIT;
                    end else if (w_is_rjmp || w_is_rcall || w_is_ret) begin
                        r_state <= FLUSH;
                    end else begin
`ifdef AVR_DECODE_ILLEGAL_TRAP_EN
                        r_illegal  <= 1'b1;
                        r_ex_class <= 4'd15;
`else
                        r_ex_valid <= 1'b1;
`endif
                    end
                end
                // Second word is a raw data address, never decoded.
                SECOND: begin
                    r_ex_valid <= 1'b1;
                    r_ex_class <= r_alt ? 4'd10 : 4'd9;
                    r_ex_rd    <= r_reg;
                    r_ex_imm   <= bus.opcode;
                    r_state    <= IDLE;
                end
                LPM_WAIT: begin
                    r_ex_valid <= 1'b1;
                    r_ex_class <= r_alt ? 4'd12 : 4'd11;
                    r_ex_rd    <= r_reg;
                    r_ex_imm   <= {8'h00, bus.lpm_data};
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ex_valid = r_ex_valid;
    assign bus.ex_class = r_ex_class;
    assign bus.ex_rd    = r_ex_rd;
    assign bus.ex_rr    = r_ex_rr;
    assign bus.ex_imm   = r_ex_imm;
endmodule

// File: tb/tb_avr_cpu_decode.sv
// Bench for avr_cpu_decode: per-cycle fetch-control checks plus a queue of expected micro-ops
// compared one cycle later; expectations for the trap option follow AVR_DECODE_ILLEGAL_TRAP_EN.
module tb_avr_cpu_decode;
    typedef struct packed {
        logic        v;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rr;
        logic [15:0] imm;
        logic        ill;
    } ex_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        hold;
        logic        ws;
        logic        rs;
        logic        lr;
        logic [15:0] la;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    ex_t  sb[$];

    avr_cpu_decode_if bus();

    avr_cpu_decode #(.RST_OPCODE(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t mk_ex(logic v, logic [3:0] c, logic [4:0] rd, logic [4:0] rr,
                                  logic [15:0] imm, logic ill);
        mk_ex = '{v: v, cls: c, rd: rd, rr: rr, imm: imm, ill: ill};
    endfunction

    function automatic ctl_t mk_ctl(logic [15:0] pc, logic h, logic ws, logic rs,
                                    logic lr, logic [15:0] la);
        mk_ctl = '{pc: pc, hold: h, ws: ws, rs: rs, lr: lr, la: la};
    endfunction

    task automatic check_ex(input string tag, input ex_t e);
        check({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(e.v));
        check({tag, ".ex_class"}, 32'(bus.ex_class), 32'(e.cls));
        check({tag, ".ex_rd"},    32'(bus.ex_rd),    32'(e.rd));
        check({tag, ".ex_rr"},    32'(bus.ex_rr),    32'(e.rr));
        check({tag, ".ex_imm"},   32'(bus.ex_imm),   32'(e.imm));
        check({tag, ".illegal"},  32'(bus.illegal),  32'(e.ill));
    endtask

    task automatic check_ctl(input string tag, input ctl_t c);
        check({tag, ".pc_update"},   32'(bus.pc_update),   32'(c.pc));
        check({tag, ".hold"},        32'(bus.hold),        32'(c.hold));
        check({tag, ".write_stack"}, 32'(bus.write_stack), 32'(c.ws));
        check({tag, ".read_stack"},  32'(bus.read_stack),  32'(c.rs));
        check({tag, ".lpm_read"},    32'(bus.lpm_read),    32'(c.lr));
        check({tag, ".lpm_addr"},    32'(bus.lpm_addr),    32'(c.la));
    endtask

    // Called just after a rising edge: drive one opcode, check fetch control, then the micro-op.
    task automatic step(input string tag, input logic [15:0] op, input logic [15:0] z,
                        input logic [7:0] ld, input ctl_t c, input ex_t e);
        ex_t got;
        bus.opcode   = op;
        bus.z_ptr    = z;
        bus.lpm_data = ld;
        #2;
        check_ctl(tag, c);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_ex(tag, got);
    endtask

    task automatic reset_check(input string tag, input logic [15:0] op);
        bus.opcode   = op;
        bus.z_ptr    = 16'h1234;
        bus.lpm_data = 8'hFF;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_ctl(tag, mk_ctl(16'h0, 0, 0, 0, 0, 16'h0));
        check_ex(tag, mk_ex(0, 0, 0, 0, 16'h0, 0));
        rst = 1'b1;
    endtask

    ctl_t c0;
    ex_t  e0;

    initial begin
        c0 = mk_ctl(16'h0, 0, 0, 0, 0, 16'h0);
        e0 = mk_ex(0, 0, 0, 0, 16'h0, 0);
        bus.opcode   = 16'h0C12;
        bus.z_ptr    = 16'h0;
        bus.lpm_data = 8'h0;
        @(posedge clk);
        #1;
        reset_check("reset", 16'h0C12);

        // ALU group and LDI
        step("add",  16'h0C12, 16'h0, 8'h0, c0, mk_ex(1, 1, 1, 2, 16'h0, 0));
        step("ldi",  16'hEA45, 16'h0, 8'h0, c0, mk_ex(1, 8, 20, 0, 16'h00A5, 0));
        step("adc",  16'h1C35, 16'h0, 8'h0, c0, mk_ex(1, 2, 3, 5, 16'h0, 0));
        step("sub",  16'h1BFF, 16'h0, 8'h0, c0, mk_ex(1, 3, 31, 31, 16'h0, 0));
        step("and",  16'h2045, 16'h0, 8'h0, c0, mk_ex(1, 4, 4, 5, 16'h0, 0));
        step("eor",  16'h2667, 16'h0, 8'h0, c0, mk_ex(1, 5, 6, 23, 16'h0, 0));
        step("or",   16'h2811, 16'h0, 8'h0, c0, mk_ex(1, 6, 1, 1, 16'h0, 0));
        step("mov",  16'h2E9A, 16'h0, 8'h0, c0, mk_ex(1, 7, 9, 26, 16'h0, 0));
        step("nop",  16'h0000, 16'h0, 8'h0, c0, mk_ex(1, 0, 0, 0, 16'h0, 0));

        // Branches: one flushed slot each, no micro-op
        step("rjmp",    16'hCFFF, 16'h0, 8'h0, mk_ctl(16'hFFFF, 1, 0, 0, 0, 16'h0), e0);
        step("rjmp_fl", 16'h0C12, 16'h0, 8'h0, c0, e0);
        step("add2",    16'h0C12, 16'h0, 8'h0, c0, mk_ex(1, 1, 1, 2, 16'h0, 0));
        step("rcall",   16'hD005, 16'h0, 8'h0, mk_ctl(16'h0005, 1, 1, 0, 0, 16'h0), e0);
        step("rcall_fl",16'h0000, 16'h0, 8'h0, c0, e0);
        step("ret",     16'h9508, 16'h0, 8'h0, mk_ctl(16'h0, 1, 0, 1, 0, 16'h0), e0);
        step("ret_fl",  16'hC005, 16'h0, 8'h0, c0, e0);
        step("rjmp_p",  16'hC7FF, 16'h0, 8'h0, mk_ctl(16'h07FF, 1, 0, 0, 0, 16'h0), e0);
        step("rjmp_pfl",16'hD003, 16'h0, 8'h0, c0, e0);

        // Two-word LDS/STS; second word never decoded
        step("lds_w1",  16'h9030, 16'h0, 8'h0, c0, e0);
        step("lds_w2",  16'h0100, 16'h0, 8'h0, c0, mk_ex(1, 9, 3, 0, 16'h0100, 0));
        step("lds_b1",  16'h9030, 16'h0, 8'h0, c0, e0);
        step("lds_b2",  16'hC005, 16'h0, 8'h0, c0, mk_ex(1, 9, 3, 0, 16'hC005, 0));
        step("sts_w1",  16'h93F0, 16'h0, 8'h0, c0, e0);
        step("sts_w2",  16'hFFFF, 16'h0, 8'h0, c0, mk_ex(1, 10, 31, 0, 16'hFFFF, 0));

        // LPM variants: hold through the wait slot, byte arrives one cycle later
        step("lpm_r0",  16'h95C8, 16'h0234, 8'h00, mk_ctl(16'h0, 1, 0, 0, 1, 16'h0234), e0);
        step("lpm_r0w", 16'h0C12, 16'h0234, 8'h5A, mk_ctl(16'h0, 1, 0, 0, 0, 16'h0),
             mk_ex(1, 11, 0, 0, 16'h005A, 0));
        step("lpm_zp",  16'h9175, 16'hBEEF, 8'h00, mk_ctl(16'h0, 1, 0, 0, 1, 16'hBEEF), e0);
        step("lpm_zpw", 16'h9508, 16'hBEEF, 8'hC3, mk_ctl(16'h0, 1, 0, 0, 0, 16'h0),
             mk_ex(1, 12, 23, 0, 16'h00C3, 0));
        step("lpm_z",   16'h90E4, 16'h8001, 8'h00, mk_ctl(16'h0, 1, 0, 0, 1, 16'h8001), e0);
        step("lpm_zw",  16'h0000, 16'h8001, 8'h80, mk_ctl(16'h0, 1, 0, 0, 0, 16'h0),
             mk_ex(1, 11, 14, 0, 16'h0080, 0));

        // Unmatched opcode
`ifdef AVR_DECODE_ILLEGAL_TRAP_EN
        step("illegal", 16'hFFFF, 16'h0, 8'h0, c0, mk_ex(0, 15, 0, 0, 16'h0, 1));
`else
        step("illegal", 16'hFFFF, 16'h0, 8'h0, c0, mk_ex(1, 0, 0, 0, 16'h0, 0));
`endif
        step("post_ill", 16'h0C12, 16'h0, 8'h0, c0, mk_ex(1, 1, 1, 2, 16'h0, 0));

        // Reset mid-sequence abandons SECOND and LPM_WAIT
        step("lds_rst", 16'h9030, 16'h0, 8'h0, c0, e0);
        reset_check("rst_mid", 16'hC005);
        step("after_rst", 16'h0C12, 16'h0, 8'h0, c0, mk_ex(1, 1, 1, 2, 16'h0, 0));
        step("lpm_rst", 16'h95C8, 16'h0040, 8'h0, mk_ctl(16'h0, 1, 0, 0, 1, 16'h0040), e0);
        reset_check("rst_lpm", 16'h0C12);
        step("after_rst2", 16'h0C12, 16'h0, 8'h0, c0, mk_ex(1, 1, 1, 2, 16'h0, 0));
        step("idle_tail", 16'hC000, 16'h0, 8'h0, mk_ctl(16'h0, 1, 0, 0, 0, 16'h0), e0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
